ucore_port_fifo: RTL and testbench

- Output-port buffer directly downstream of a generated microcoded FSM core.
- Captures single-cycle port write strobes from the core and presents them to the consuming logic as a valid/ready stream.
- Returns a stall signal so the core's next-state logic can hold its current state until space is free.
- Records writes dropped when the core ignores the stall signal.

---
 rtl/ucore_port_fifo.sv | 113 +++++++++++
 tb/tb_ucore_port_fifo.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/ucore_port_fifo.sv
// Output-port FIFO between a microcoded FSM core and a valid/ready consumer.
// Optional event counters are compiled in with UCORE_PORT_FIFO_STATS_EN.
module ucore_port_fifo #(
   parameter int WIDTH        = 32,
   parameter int DEPTH        = 4,
   parameter int STALL_MARGIN = 1
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic                       wr_en,
   input  logic [WIDTH-1:0]           wr_data,
   output logic                       stall,
   output logic                       out_valid,
   output logic [WIDTH-1:0]           out_data,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       overflow,
`ifdef UCORE_PORT_FIFO_STATS_EN
   output logic [15:0]                push_count,
   output logic [15:0]                pop_count,
   output logic [15:0]                drop_count,
`endif
   input  logic                       clr_overflow
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;
   localparam logic [LW-1:0] FULL_LVL  = LW'(DEPTH);
   localparam logic [LW-1:0] STALL_LVL = LW'(DEPTH - STALL_MARGIN);

   if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("ucore_port_fifo: DEPTH must be a power of two >= 2");
   end
   if ((STALL_MARGIN < 1) || (STALL_MARGIN > DEPTH - 1)) begin : g_bad_margin
      $error("ucore_port_fifo: STALL_MARGIN must be in 1..DEPTH-1");
   end

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]    level_q, level_d;
   logic             ovf_q, ovf_d;
   logic             full, push, pop, drop;

   assign full = (level_q == FULL_LVL);
   assign pop  = out_valid && out_ready;
   // A pop in the same cycle frees the slot, so a write into a full FIFO still lands.
   assign push = wr_en && (!full || pop);
   assign drop = wr_en && full && !pop;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      ovf_d    = ovf_q;
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
      if (clr_overflow) ovf_d = 1'b0;
      if (drop)         ovf_d = 1'b1;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         ovf_q    <= ovf_d;
      end
   end

   // Storage needs no reset: nothing is visible until level goes non-zero.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= wr_data;
   end

   // Outputs depend only on registered state, never on wr_en or out_ready.
   assign out_valid = (level_q != '0);
   assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
   assign stall     = (level_q >= STALL_LVL);
   assign level     = level_q;
   assign overflow  = ovf_q;

`ifdef UCORE_PORT_FIFO_STATS_EN
   logic [15:0] push_cnt_q, pop_cnt_q, drop_cnt_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         push_cnt_q <= '0;
         pop_cnt_q  <= '0;
         drop_cnt_q <= '0;
      end else begin
         if (push) push_cnt_q <= push_cnt_q + 16'd1;
         if (pop)  pop_cnt_q  <= pop_cnt_q + 16'd1;
         if (drop) drop_cnt_q <= drop_cnt_q + 16'd1;
      end
   end

   assign push_count = push_cnt_q;
   assign pop_count  = pop_cnt_q;
   assign drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_ucore_port_fifo.sv
// Directed vector bench for ucore_port_fifo (WIDTH=32, DEPTH=4, STALL_MARGIN=1).
module tb_ucore_port_fifo;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        wr_en = 1'b0;
   logic [31:0] wr_data = '0;
   logic        stall;
   logic        out_valid;
   logic [31:0] out_data;
   logic        out_ready = 1'b0;
   logic [2:0]  level;
   logic        overflow;
   logic        clr_overflow = 1'b0;
`ifdef UCORE_PORT_FIFO_STATS_EN
   logic [15:0] push_count, pop_count, drop_count;
`endif

   int nvec = 0;
   int nfail = 0;

   always #5 clk = ~clk;

   ucore_port_fifo #(.WIDTH(32), .DEPTH(4), .STALL_MARGIN(1)) dut (
      .clk(clk), .resetn(resetn), .wr_en(wr_en), .wr_data(wr_data),
      .stall(stall), .out_valid(out_valid), .out_data(out_data),
      .out_ready(out_ready), .level(level), .overflow(overflow),
`ifdef UCORE_PORT_FIFO_STATS_EN
      .push_count(push_count), .pop_count(pop_count), .drop_count(drop_count),
`endif
      .clr_overflow(clr_overflow)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Inputs applied this cycle, and the outputs expected before its clock edge.
   typedef struct {
      logic        wr;
      logic [31:0] d;
      logic        rdy;
      logic        clr;
      logic        ev;
      logic [31:0] edata;
      logic [2:0]  elvl;
      logic        est;
      logic        eovf;
   } vec_t;

   localparam int NV = 16;
   vec_t tbl [NV];
   logic [31:0] sb [$];

   initial begin
      // basic single word
      tbl[0]  = '{1'b1, 32'hA5A5_0001, 1'b1, 1'b0, 1'b0, 32'h0,         3'd0, 1'b0, 1'b0};
      tbl[1]  = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 32'hA5A5_0001, 3'd1, 1'b0, 1'b0};
      // fill with consumer stalled
      tbl[2]  = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 3'd0, 1'b0, 1'b0};
      tbl[3]  = '{1'b1, 32'd1, 1'b0, 1'b0, 1'b0, 32'h0, 3'd0, 1'b0, 1'b0};
      tbl[4]  = '{1'b1, 32'd2, 1'b0, 1'b0, 1'b1, 32'd1, 3'd1, 1'b0, 1'b0};
      tbl[5]  = '{1'b1, 32'd3, 1'b0, 1'b0, 1'b1, 32'd1, 3'd2, 1'b0, 1'b0};
      tbl[6]  = '{1'b1, 32'd4, 1'b0, 1'b0, 1'b1, 32'd1, 3'd3, 1'b1, 1'b0};
      // full: push 5 with concurrent pop of 1
      tbl[7]  = '{1'b1, 32'd5, 1'b1, 1'b0, 1'b1, 32'd1, 3'd4, 1'b1, 1'b0};
      // full: drop 9, then drop+clear (set wins), then clear alone
      tbl[8]  = '{1'b1, 32'd9, 1'b0, 1'b0, 1'b1, 32'd2, 3'd4, 1'b1, 1'b0};
      tbl[9]  = '{1'b1, 32'd9, 1'b0, 1'b1, 1'b1, 32'd2, 3'd4, 1'b1, 1'b1};
      tbl[10] = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'd2, 3'd4, 1'b1, 1'b1};
      // drain 2,3,4,5; stall falls at level 2
      tbl[11] = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'd2, 3'd4, 1'b1, 1'b0};
      tbl[12] = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'd3, 3'd3, 1'b1, 1'b0};
      tbl[13] = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'd4, 3'd2, 1'b0, 1'b0};
      tbl[14] = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'd5, 3'd1, 1'b0, 1'b0};
      tbl[15] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 3'd0, 1'b0, 1'b0};

      // reset state
      repeat (2) @(negedge clk);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_level", 32'(level), 32'd0);
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);
      chk("rst_data", out_data, 32'd0);
      resetn = 1'b1;

      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         wr_en = tbl[i].wr; wr_data = tbl[i].d;
         out_ready = tbl[i].rdy; clr_overflow = tbl[i].clr;
         chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'(tbl[i].ev));
         if (tbl[i].ev) chk($sformatf("v%0d_data", i), out_data, tbl[i].edata);
         chk($sformatf("v%0d_level", i), 32'(level), 32'(tbl[i].elvl));
         chk($sformatf("v%0d_stall", i), 32'(stall), 32'(tbl[i].est));
         chk($sformatf("v%0d_ovf", i), 32'(overflow), 32'(tbl[i].eovf));
      end

      // pointer wrap: 10 words, out_ready toggling, scoreboard order check
      begin
         int sent = 0, got = 0, cyc = 0;
         logic pop_m, push_m;
         sb.delete();
         while (got < 10 && cyc < 60) begin
            @(negedge clk);
            out_ready = (cyc % 2 == 0);
            wr_en = (sent < 10) && (sb.size() < 3);
            wr_data = 32'h100 + 32'(sent);
            clr_overflow = 1'b0;
            chk("wrap_level", 32'(level), 32'(sb.size()));
            if (sb.size() != 0) chk("wrap_data", out_data, sb[0]);
            pop_m = (sb.size() != 0) && out_ready;
            push_m = wr_en;
            if (pop_m) begin void'(sb.pop_front()); got++; end
            if (push_m) begin sb.push_back(wr_data); sent++; end
            cyc++;
         end
         if (got < 10) chk("wrap_timeout", 32'(got), 32'd10);
      end

      // async reset while holding three words
      @(negedge clk);
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         wr_en = 1'b1; wr_data = 32'h200 + 32'(k);
         @(negedge clk);
      end
      wr_en = 1'b0;
      chk("pre_rst_level", 32'(level), 32'd3);
      #2 resetn = 1'b0;
      #1;
      chk("arst_valid", 32'(out_valid), 32'd0);
      chk("arst_level", 32'(level), 32'd0);
      chk("arst_stall", 32'(stall), 32'd0);
      @(negedge clk);
      resetn = 1'b1;
      wr_en = 1'b1; wr_data = 32'h77;
      @(negedge clk);
      wr_en = 1'b0;
      chk("post_rst_valid", 32'(out_valid), 32'd1);
      chk("post_rst_data", out_data, 32'h77);
      chk("post_rst_level", 32'(level), 32'd1);

`ifdef UCORE_PORT_FIFO_STATS_EN
      resetn = 1'b0;
      @(negedge clk);
      chk("st_rst_push", 32'(push_count), 32'd0);
      resetn = 1'b1;
      wr_en = 1'b1; out_ready = 1'b1;
      for (int k = 0; k < 70000; k++) begin
         wr_data = 32'(k);
         @(negedge clk);
      end
      wr_en = 1'b0;
      @(negedge clk);
      chk("st_push", 32'(push_count), 32'd4464);
      chk("st_pop", 32'(pop_count), 32'd4464);
      chk("st_level", 32'(level), 32'd0);
      out_ready = 1'b0; wr_en = 1'b1;
      repeat (5) @(negedge clk);
      wr_en = 1'b0;
      @(negedge clk);
      chk("st_drop", 32'(drop_count), 32'd1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
